// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared SD SPI command indices, R1 layout, OCR window and FSM states
package sd_spi_pkg;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD8  = 6'd8;
   localparam logic [5:0] CMD41 = 6'd41;
   localparam logic [5:0] CMD55 = 6'd55;
   localparam logic [5:0] CMD58 = 6'd58;

   localparam int R1_IDLE    = 0;
   localparam int R1_ILLEGAL = 2;
   localparam int R1_CRC     = 3;

   localparam logic [23:0] OCR_VOLT_WINDOW = 24'hFF8000;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_RECV,
      ST_EVAL,
      ST_NCR,
      ST_RESP
   } spi_state_t;

   function automatic logic [7:0] make_r1(input logic crc_err, input logic illegal,
                                          input logic idle);
      logic [7:0] r;
      r             = 8'h00;
      r[R1_CRC]     = crc_err;
      r[R1_ILLEGAL] = illegal;
      r[R1_IDLE]    = idle;
      return r;
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7 + x^3 + 1), MSB-first, zero init
module sd_crc7 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic fb;
   assign fb = bit_in ^ crc[6];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         crc <= '0;
      else if (clear)
         crc <= '0;
      else if (enable)
         crc <= {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
   end

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card responder for the init command subset
module sd_spi_responder
   import sd_spi_pkg::*;
#(
   parameter int NCR_BYTES  = 1,
   parameter int INIT_POLLS = 2,
   parameter int CHECK_CRC  = 1,
   parameter int CCS        = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_clk,
   input  logic        cs,
   input  logic        mosi,
   output logic        miso,
   output logic        cmd_strobe,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        crc_error,
   output logic        card_idle
);

   localparam logic [6:0]    NCR_LAST   = 7'(NCR_BYTES * 8 - 1);
   localparam int            PW         = (INIT_POLLS < 2) ? 1 : $clog2(INIT_POLLS + 1);
   localparam logic [PW-1:0] POLLS_INIT = PW'(INIT_POLLS);
   localparam logic          CHK        = (CHECK_CRC != 0);
   localparam logic          CCS_BIT    = (CCS != 0);

   logic [2:0] sclk_s;
   logic [1:0] cs_s;
   logic [1:0] mosi_s;
   logic       rise, fall, cs_hi, sdi;

   assign rise  = sclk_s[1] & ~sclk_s[2];
   assign fall  = ~sclk_s[1] & sclk_s[2];
   assign cs_hi = cs_s[1];
   assign sdi   = mosi_s[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_s <= 3'b000;
         cs_s   <= 2'b11;
         mosi_s <= 2'b11;
      end else begin
         sclk_s <= {sclk_s[1:0], spi_clk};
         cs_s   <= {cs_s[0], cs};
         mosi_s <= {mosi_s[0], mosi};
      end
   end

   spi_state_t     state;
   logic [5:0]     bit_cnt;
   logic [6:0]     tx_cnt;
   logic [6:0]     resp_last;
   logic [44:0]    frame_sr;   // frame bits 45..1; start and stop bits are not kept
   logic [39:0]    resp_sr;
   logic           app;
   logic [PW-1:0]  polls;
   logic [6:0]     crc;
   logic           crc_clear, crc_en;

   // The start bit is always 0, so holding the CRC cleared through it is equivalent to feeding it.
   assign crc_clear = (state == ST_HUNT);
   assign crc_en    = (state == ST_RECV) && rise && (bit_cnt < 6'd40);

   sd_crc7 u_crc7 (
      .clk    (clk),
      .rst    (rst),
      .clear  (crc_clear),
      .enable (crc_en),
      .bit_in (sdi),
      .crc    (crc)
   );

   logic [7:0]    ev_r1;
   logic [31:0]   ev_tail;
   logic          ev_long, ev_idle, ev_app;
   logic [PW-1:0] ev_polls;

   always_comb begin
      ev_r1    = make_r1(1'b0, 1'b0, card_idle);
      ev_tail  = '1;
      ev_long  = 1'b0;
      ev_idle  = card_idle;
      ev_app   = 1'b0;
      ev_polls = polls;
      if (crc_error && CHK) begin
         ev_r1 = make_r1(1'b1, 1'b0, card_idle);
      end else begin
         case (cmd_index)
            CMD0: begin
               ev_idle  = 1'b1;
               ev_polls = POLLS_INIT;
               ev_r1    = make_r1(1'b0, 1'b0, 1'b1);
            end
            CMD8: begin
               ev_long = 1'b1;
               ev_tail = {16'h0000, 4'h0, cmd_arg[11:0]};
            end
            CMD55: ev_app = 1'b1;
            CMD41: begin
               if (!app)
                  ev_r1 = make_r1(1'b0, 1'b1, card_idle);
               else if (polls == '0) begin
                  ev_idle = 1'b0;
                  ev_r1   = 8'h00;
               end else begin
                  ev_polls = polls - 1'b1;
                  ev_r1    = make_r1(1'b0, 1'b0, 1'b1);
               end
            end
            CMD58: begin
               ev_long = 1'b1;
               ev_tail = {~card_idle, CCS_BIT, 6'b000000, OCR_VOLT_WINDOW};
            end
            default: ev_r1 = make_r1(1'b0, 1'b1, card_idle);
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_HUNT;
         bit_cnt    <= '0;
         tx_cnt     <= '0;
         resp_last  <= '0;
         frame_sr   <= '0;
         resp_sr    <= '1;
         miso       <= 1'b1;
         cmd_strobe <= 1'b0;
         cmd_index  <= '0;
         cmd_arg    <= '0;
         crc_error  <= 1'b0;
         card_idle  <= 1'b1;
         app        <= 1'b0;
         polls      <= POLLS_INIT;
      end else begin
         cmd_strobe <= 1'b0;
         if (cs_hi) begin
            state <= ST_HUNT;
            miso  <= 1'b1;
         end else begin
            case (state)
               ST_HUNT: begin
                  if (fall)
                     miso <= 1'b1;
                  if (rise && !sdi) begin
                     state    <= ST_RECV;
                     bit_cnt  <= 6'd1;
                     frame_sr <= {frame_sr[43:0], sdi};
                  end
               end
               ST_RECV: begin
                  if (fall)
                     miso <= 1'b1;
                  if (rise) begin
                     if (bit_cnt == 6'd1 && !sdi)
                        state <= ST_HUNT;
                     else if (bit_cnt == 6'd47) begin
                        state      <= ST_EVAL;
                        cmd_strobe <= 1'b1;
                        cmd_index  <= frame_sr[44:39];
                        cmd_arg    <= frame_sr[38:7];
                        crc_error  <= (crc != frame_sr[6:0]);
                     end else begin
                        bit_cnt  <= bit_cnt + 6'd1;
                        frame_sr <= {frame_sr[43:0], sdi};
                     end
                  end
               end
               ST_EVAL: begin
                  card_idle <= ev_idle;
                  app       <= ev_app;
                  polls     <= ev_polls;
                  resp_sr   <= {ev_r1, ev_tail};
                  resp_last <= ev_long ? 7'd39 : 7'd7;
                  tx_cnt    <= '0;
                  state     <= ST_NCR;
               end
               ST_NCR: begin
                  if (fall) begin
                     miso <= 1'b1;
                     if (tx_cnt == NCR_LAST) begin
                        tx_cnt <= '0;
                        state  <= ST_RESP;
                     end else
                        tx_cnt <= tx_cnt + 7'd1;
                  end
               end
               ST_RESP: begin
                  if (fall) begin
                     miso    <= resp_sr[39];
                     resp_sr <= {resp_sr[38:0], 1'b1};
                     if (tx_cnt == resp_last)
                        state <= ST_HUNT;
                     else
                        tx_cnt <= tx_cnt + 7'd1;
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - self-checking bench: SPI host driver plus card-level reference model
module tb_sd_spi_responder;

   localparam int NCR   = 1;
   localparam int POLLS = 2;
   localparam int HALF  = 5;

   logic        clk = 1'b0;
   logic        rst, spi_clk, cs, mosi;
   logic        miso, cmd_strobe, crc_error, card_idle;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;

   int checks = 0;
   int errors = 0;
   int strobes = 0;
   int cs_hi_cnt = 0;

   bit          m_idle = 1'b1;
   bit          m_app = 1'b0;
   int          m_polls = POLLS;
   bit          exp_pending = 1'b0;
   logic [5:0]  exp_idx = '0;
   logic [31:0] exp_arg = '0;
   bit          exp_crc = 1'b0;
   logic [7:0]  exp_bytes[$];
   logic [7:0]  got[$];
   logic [5:0]  set_idx[5] = '{6'd0, 6'd8, 6'd41, 6'd55, 6'd58};

   sd_spi_responder #(
      .NCR_BYTES  (NCR),
      .INIT_POLLS (POLLS),
      .CHECK_CRC  (1),
      .CCS        (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_clk    (spi_clk),
      .cs         (cs),
      .mosi       (mosi),
      .miso       (miso),
      .cmd_strobe (cmd_strobe),
      .cmd_index  (cmd_index),
      .cmd_arg    (cmd_arg),
      .crc_error  (crc_error),
      .card_idle  (card_idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // Card-level model: what the card must answer and how its state moves.
   task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit bad);
      exp_bytes.delete();
      for (int i = 0; i < NCR; i++) exp_bytes.push_back(8'hFF);
      if (bad) begin
         m_app = 1'b0;
         exp_bytes.push_back(8'h08 | {7'b0, m_idle});
         return;
      end
      case (idx)
         6'd0: begin
            m_idle = 1'b1; m_polls = POLLS; m_app = 1'b0;
            exp_bytes.push_back(8'h01);
         end
         6'd8: begin
            m_app = 1'b0;
            exp_bytes.push_back({7'b0, m_idle});
            exp_bytes.push_back(8'h00);
            exp_bytes.push_back(8'h00);
            exp_bytes.push_back({4'h0, arg[11:8]});
            exp_bytes.push_back(arg[7:0]);
         end
         6'd55: begin
            m_app = 1'b1;
            exp_bytes.push_back({7'b0, m_idle});
         end
         6'd41: begin
            if (!m_app) exp_bytes.push_back(8'h04 | {7'b0, m_idle});
            else if (m_polls == 0) begin
               m_idle = 1'b0;
               exp_bytes.push_back(8'h00);
            end else begin
               m_polls--;
               exp_bytes.push_back(8'h01);
            end
            m_app = 1'b0;
         end
         6'd58: begin
            m_app = 1'b0;
            exp_bytes.push_back({7'b0, m_idle});
            exp_bytes.push_back({~m_idle, 1'b1, 6'b0});
            exp_bytes.push_back(8'hFF);
            exp_bytes.push_back(8'h80);
            exp_bytes.push_back(8'h00);
         end
         default: begin
            m_app = 1'b0;
            exp_bytes.push_back(8'h04 | {7'b0, m_idle});
         end
      endcase
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b1;
         rx[i] = miso;
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [7:0] crc_xor);
      logic [7:0] fr[6];
      logic [7:0] rx;
      fr[0] = {2'b01, idx};
      fr[1] = arg[31:24]; fr[2] = arg[23:16]; fr[3] = arg[15:8]; fr[4] = arg[7:0];
      fr[5] = {crc7({fr[0], fr[1], fr[2], fr[3], fr[4]}), 1'b1} ^ crc_xor;
      exp_idx = idx; exp_arg = arg; exp_crc = (crc_xor[7:1] != 7'd0); exp_pending = 1'b1;
      cs = 1'b0;
      for (int i = 0; i < 6; i++) begin
         xfer(fr[i], rx);
         check("frame_miso", rx, 8'hFF);
      end
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc_xor);
      logic [7:0] rx;
      model_cmd(idx, arg, crc_xor[7:1] != 7'd0);
      send_frame(idx, arg, crc_xor);
      got.delete();
      foreach (exp_bytes[i]) begin
         xfer(8'hFF, rx);
         got.push_back(rx);
         check($sformatf("resp_cmd%0d_byte%0d", idx, i), rx, exp_bytes[i]);
      end
      check("strobe_seen", exp_pending, 1'b0);
      check("card_idle", card_idle, m_idle);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_strobe) begin
            check("strobe_expected", exp_pending, 1'b1);
            check("cmd_index", cmd_index, exp_idx);
            check("cmd_arg", cmd_arg, exp_arg);
            check("crc_error", crc_error, exp_crc);
            exp_pending = 1'b0;
            strobes++;
         end
         if (cs_hi_cnt >= 4) check("miso_cs_high", miso, 1'b1);
      end
      if (cs) cs_hi_cnt++;
      else cs_hi_cnt = 0;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rx;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  cx;
      int          s0;

      rst = 1'b1; spi_clk = 1'b0; cs = 1'b1; mosi = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_miso", miso, 1'b1);
      check("rst_strobe", cmd_strobe, 1'b0);
      check("rst_index", cmd_index, 6'd0);
      check("rst_arg", cmd_arg, 32'd0);
      check("rst_crc_error", crc_error, 1'b0);
      check("rst_card_idle", card_idle, 1'b1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      check("crc7_cmd0", crc7(40'h40_0000_0000), 7'h4A);
      check("crc7_cmd8", crc7(40'h48_0000_01AA), 7'h43);

      for (int i = 0; i < 80; i++) begin
         mosi = 1'($urandom_range(0, 1));
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b0;
      end
      check("cs_high_no_strobe", strobes, 0);

      run_cmd(6'd0, 32'h0, 8'h94);
      check("bad_cmd0_r1", got[NCR], 8'h09);
      check("bad_cmd0_crc_error", crc_error, 1'b1);
      run_cmd(6'd41, 32'h4000_0000, 8'h00);
      check("cmd41_no_app_r1", got[NCR], 8'h05);

      run_cmd(6'd0, 32'h0, 8'h00);
      check("cmd0_ncr", got[0], 8'hFF);
      check("cmd0_r1", got[1], 8'h01);
      check("cmd0_index", cmd_index, 6'd0);
      check("cmd0_crc_error", crc_error, 1'b0);
      check("cmd0_strobes", strobes, 3);

      run_cmd(6'd8, 32'h0000_01AA, 8'h00);
      check("cmd8_bytes", {got[0], got[1], got[2], got[3], got[4], got[5]}, 48'hFF01_0000_01AA);
      check("cmd8_arg", cmd_arg, 32'h0000_01AA);

      for (int p = 0; p < 3; p++) begin
         run_cmd(6'd55, 32'h0, 8'h00);
         run_cmd(6'd41, 32'h4000_0000, 8'h00);
         check($sformatf("acmd41_r1_%0d", p), got[NCR], (p == 2) ? 8'h00 : 8'h01);
      end
      check("ready_card_idle", card_idle, 1'b0);
      run_cmd(6'd58, 32'h0, 8'h00);
      check("cmd58_r3", {got[1], got[2], got[3], got[4], got[5]}, 40'h00_C0FF_8000);

      s0 = strobes;
      cs = 1'b0;
      xfer(8'h7A, rx); check("abort_miso0", rx, 8'hFF);
      xfer(8'h00, rx); check("abort_miso1", rx, 8'hFF);
      xfer(8'h00, rx); check("abort_miso2", rx, 8'hFF);
      cs = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_strobe", strobes, s0);
      run_cmd(6'd58, 32'h0, 8'h00);
      check("after_abort_r3", {got[1], got[2], got[3], got[4], got[5]}, 40'h00_C0FF_8000);

      send_frame(6'd58, 32'h0, 8'h00);
      for (int i = 0; i < NCR; i++) xfer(8'hFF, rx);
      mosi = 1'b1;
      for (int b = 0; b < 4; b++) begin
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_clk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      check("r1_bit_before_rst", miso, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_mid_miso", miso, 1'b1);
      check("rst_mid_card_idle", card_idle, 1'b1);
      check("rst_mid_index", cmd_index, 6'd0);
      m_idle = 1'b1; m_app = 1'b0; m_polls = POLLS; exp_pending = 1'b0;
      spi_clk = 1'b0; cs = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int n = 0; n < 30; n++) begin
         cx  = 8'h00;
         arg = 32'h0;
         case ($urandom_range(0, 8))
            0: idx = 6'd0;
            1: begin idx = 6'd8; arg = $urandom; end
            2, 3: idx = 6'd55;
            4, 5: begin idx = 6'd41; arg = 32'h4000_0000; end
            6: idx = 6'd58;
            7: begin
               idx = 6'($urandom_range(1, 63));
               while (idx inside {6'd8, 6'd41, 6'd55, 6'd58}) idx = 6'($urandom_range(1, 63));
               arg = $urandom;
            end
            default: begin
               idx = set_idx[$urandom_range(0, 4)];
               arg = $urandom;
               cx  = 8'(1 << $urandom_range(1, 7));
            end
         endcase
         if ($urandom_range(0, 2) == 0) begin
            cs = 1'b1;
            repeat ($urandom_range(3, 20)) @(negedge clk);
         end
         run_cmd(idx, arg, cx);
      end

      cs = 1'b1;
      repeat (10) @(negedge clk);
      check("final_no_pending", exp_pending, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SPI-mode SD card responder: the card end of the link driven by our SD card controller. It runs on the system clock, oversamples the host's `spi_clk`/`cs`/`mosi`, and parses 48-bit command frames. It executes the init subset (CMD0, CMD8, CMD55, ACMD41, CMD58) and shifts R1/R3/R7 responses out on `miso`. It serves as the synthesizable card model for controller benches and for loopback tests on the board.

## Interface
- `NCR_BYTES`, default 1: 0xFF filler bytes between the command stop bit and the response. Legal range 1–8.
- `INIT_POLLS`, default 2: number of ACMD41s answered "still idle" (0x01) before the card reports ready.
- `CHECK_CRC`, default 1: when 1, a CRC7 mismatch rejects the command. When 0, the CRC field is ignored.
- `CCS`, default 1: the OCR[30] card capacity status bit reported by CMD58.
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `spi_clk` input 1: host SPI clock. Mode 0, idles low. Asynchronous to `clk`.
- `cs` input 1: chip select, active low.
- `mosi` input 1: host-to-card data.
- `miso` output 1: card-to-host data. Reset value 1.
- `cmd_strobe` output 1: one-`clk` pulse per complete frame. Reset value 0.
- `cmd_index` output 6: index of the last frame. Reset value 0.
- `cmd_arg` output 32: argument of the last frame. Reset value 0.
- `crc_error` output 1: CRC result of the last frame, valid with `cmd_strobe`. Reset value 0.
- `card_idle` output 1: R1 idle bit. Reset value 1.

## Operation
- Input sync: `spi_clk`, `cs` and `mosi` each pass through a 2-flop synchronizer. A third flop on `spi_clk` gives rise/fall detection. `mosi` is sampled on a detected rise.
- `cs` high: `miso` = 1. Any in-progress frame or response is abandoned and the FSM returns to HUNT. Card state (idle, app flag, poll counter) is retained.
- FSM states:
  - HUNT: wait for a sampled 0 bit (bit-aligned start bit), then go to RECV with bit count 1.
  - RECV: shift in bits up to 48. If bit 1 ≠ 1 (transmission bit), return to HUNT. At bit 48, go to EVAL.
  - EVAL: one `clk`. Run checks, update card state, pulse `cmd_strobe`, load the response shifter, go to NCR.
  - NCR: drive 1 for `NCR_BYTES`×8 bits, then go to RESP.
  - RESP: shift the response out MSB first. Go to HUNT after the last bit.
  - `mosi` is ignored in NCR and RESP.
- R1 = {0, 0, 0, 0, crc_err, illegal, 0, idle}.
- CRC7 (poly x^7+x^3+1, init 0) covers frame bits 47..8 and is compared with bits 7..1. The stop bit (bit 0) is not checked.
- CRC mismatch with `CHECK_CRC`=1: R1 = 0x08 | idle, the command is not executed, and the app flag is cleared.
- CMD0: idle←1, poll counter←`INIT_POLLS`, app flag←0. Response R1 = 0x01.
- CMD8: R7 = R1, 0x00, 0x00, {4'b0, arg[11:8]}, arg[7:0] (5 bytes).
- CMD55: app flag←1. Response R1.
- ACMD41 (CMD41 with app flag set):
  - poll counter = 0: idle←0, R1 = 0x00.
  - otherwise: counter decrements, R1 = 0x01.
- CMD58: R3 = R1, then OCR = {~idle, CCS, 6'b0, 24'hFF8000}, MSB first.
- CMD41 without the app flag, or any other index: R1 = 0x04 | idle.
- The app flag clears after every command other than CMD55.

## Timing
- `spi_clk` half-period must be ≥ 4 `clk` cycles (f_spi ≤ f_clk/8).
- Sample point: `mosi` is captured 3 `clk` cycles after the physical rise.
- `miso` updates on a detected fall, presenting the bit for the next rise.
- The first NCR bit is driven on the fall following the stop-bit rise.
- Rise-to-EVAL: EVAL occurs 1 `clk` after the stop bit is sampled, and `cmd_strobe` is asserted in that cycle.
- `cs` rising mid-frame: `miso` returns to 1 within 3 `clk` cycles, with no strobe.
- `rst` asserted at any point: all outputs go to their reset values immediately, and the FSM goes to HUNT.
- `cmd_index`/`cmd_arg` hold their values until the next strobe.

## Structure
- `sd_spi_pkg`: command index constants (CMD0/8/41/55/58), R1 bit positions, the OCR voltage window constant, and the FSM state enum. Share this package with the controller.
- Sub-module `sd_crc7`: serial CRC7 with `clk`, `rst`, `clear`, `enable` and `bit_in` inputs and a `crc[6:0]` output.

## Test plan
- Reset, then 80 `spi_clk` cycles with `cs` high: `miso` stays 1 and `cmd_strobe` never pulses.
- CMD0 frame 40 00 00 00 00 95, then 0xFF bytes: `miso` bytes FF, 01; `cmd_strobe` pulses once, `cmd_index` = 0, `crc_error` = 0.
- CMD8 frame 48 00 00 01 AA 87: `miso` bytes FF, 01, 00, 00, 01, AA; `cmd_arg` = 0x000001AA.
- With `INIT_POLLS`=2, three CMD55+ACMD41 pairs (77 00 00 00 00 65 / 69 40 00 00 00 77): ACMD41 R1s are 01, 01, 00, and `card_idle` falls after the third. A following CMD58 returns 00, C0, FF, 80, 00.
- CMD0 with CRC byte 0x01: R1 = 0x09, `crc_error` = 1, and state is unchanged. A following CMD41 without CMD55 returns 0x05 (or 0x04 if already ready).
- `cs` raised after 3 bytes of a frame, then a full CMD58: no strobe for the aborted frame and a correct R3 for CMD58. `rst` asserted mid-R3: `miso` = 1 and `card_idle` = 1 immediately.
